// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// State encoding, minimum prescale and sample-window offsets.
package uart_rx_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
  localparam logic [2:0] S_PARITY   = 3'd3;
  localparam logic [2:0] S_STOP1    = 3'd4;
  localparam logic [2:0] S_STOP2    = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [2:0] S_BRK_WAIT = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_START    = S_START,
    ST_DATA     = S_DATA,
    ST_PARITY   = S_PARITY,
    ST_STOP1    = S_STOP1,
    ST_STOP2    = S_STOP2,
    ST_DONE     = S_DONE,
    ST_BRK_WAIT = S_BRK_WAIT
  } rx_state_e;

  localparam int MIN_PRESCALE = 8;

  // Taps sit at P/2-1, P/2, P/2+1; vote is ready at P/2+2.
  localparam int TAP_LO_SUB = 1;
  localparam int TAP_HI_ADD = 1;
  localparam int DONE_ADD   = 2;

endpackage

// File: rtl/uart_rx_if.sv
// Configuration, serial line and status bundle of the RX controller.
// master = line/config driver, slave = receiver.
interface uart_rx_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);

  logic                      RX_IN;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic                      STP2;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      Data_Valid;
  logic                      Par_Err;
  logic                      Stp_Err;
  logic                      Brk_Det;
  logic                      Busy;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, STP2, Prescale,
    input  P_DATA, Data_Valid, Par_Err,
    input  Stp_Err, Brk_Det, Busy
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, STP2, Prescale,
    output P_DATA, Data_Valid, Par_Err,
    output Stp_Err, Brk_Det, Busy
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Oversampling edge counter with 3-tap majority vote.
// Emits samp_done mid-bit and bit_end on the last edge of a bit.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      rx_s,
  output logic                      samp_done,
  output logic                      bit_end,
  output logic                      maj
);

  typedef logic [PRESCALE_WIDTH-1:0] cnt_t;

  cnt_t       edge_q;
  cnt_t       edge_d;
  cnt_t       half;
  logic [2:0] tap_q;
  logic [2:0] tap_d;

  always_comb begin
    half      = prescale >> 1;
    bit_end   = enable &&
                (edge_q == prescale - cnt_t'(1));
    samp_done = enable &&
                (edge_q == half + cnt_t'(DONE_ADD));
    maj       = (tap_q[0] & tap_q[1]) |
                (tap_q[0] & tap_q[2]) |
                (tap_q[1] & tap_q[2]);
    edge_d    = '0;
    if (enable && !bit_end) begin
      edge_d = edge_q + cnt_t'(1);
    end
    tap_d = tap_q;
    if (enable) begin
      if (edge_q == half - cnt_t'(TAP_LO_SUB)) begin
        tap_d[0] = rx_s;
      end
      if (edge_q == half) begin
        tap_d[1] = rx_s;
      end
      if (edge_q == half + cnt_t'(TAP_HI_ADD)) begin
        tap_d[2] = rx_s;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_q <= '0;
      tap_q  <= '1;
    end else begin
      edge_q <= edge_d;
      tap_q  <= tap_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, deserializer, parity,
// framing and break detection with registered status pulses.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int SYNC_STAGES    = 2
) (
  input  logic     CLK,
  input  logic     RST,
  uart_rx_if.slave bus
);

  localparam int BW = $clog2(DATA_WIDTH);

  typedef logic [DATA_WIDTH-1:0]     word_t;
  typedef logic [PRESCALE_WIDTH-1:0] psc_t;
  typedef logic [BW-1:0]             bcnt_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  rx_state_e state_q, state_d;
  bcnt_t     bit_q, bit_d;
  word_t     shreg_q, shreg_d;
  word_t     pdata_q, pdata_d;
  psc_t      presc_q, presc_d;
  logic      par_en_q, par_en_d;
  logic      par_typ_q, par_typ_d;
  logic      stp2_q, stp2_d;
  logic      par_bad_q, par_bad_d;
  logic      stp_bad_q, stp_bad_d;
  logic      brk_q, brk_d;
  logic      par_bit_q, par_bit_d;
  logic      dv_q, dv_d;
  logic      pe_q, pe_d;
  logic      se_q, se_d;
  logic      bd_q, bd_d;
  logic      busy_q, busy_d;

  logic rx_s;
  logic samp_en;
  logic samp_done;
  logic bit_end;
  logic maj;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign samp_en = (state_q != ST_IDLE) &&
                   (state_q != ST_DONE) &&
                   (state_q != ST_BRK_WAIT);

  uart_rx_sampler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_samp (
    .CLK       (CLK),
    .RST       (RST),
    .enable    (samp_en),
    .prescale  (presc_q),
    .rx_s      (rx_s),
    .samp_done (samp_done),
    .bit_end   (bit_end),
    .maj       (maj)
  );

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], bus.RX_IN};
    state_d   = state_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    pdata_d   = pdata_q;
    presc_d   = presc_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    stp2_d    = stp2_q;
    par_bad_d = par_bad_q;
    stp_bad_d = stp_bad_q;
    brk_d     = brk_q;
    par_bit_d = par_bit_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;
    bd_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d   = ST_START;
          par_en_d  = bus.PAR_EN;
          par_typ_d = bus.PAR_TYP;
          stp2_d    = bus.STP2;
          // Clamp to the minimum and force even.
          if (bus.Prescale < psc_t'(MIN_PRESCALE)) begin
            presc_d = psc_t'(MIN_PRESCALE);
          end else begin
            presc_d = {bus.Prescale[PRESCALE_WIDTH-1:1], 1'b0};
          end
          par_bad_d = 1'b0;
          stp_bad_d = 1'b0;
          brk_d     = 1'b0;
          par_bit_d = 1'b0;
        end
      end
      ST_START: begin
        if (samp_done && maj) begin
          state_d = ST_IDLE;
        end else if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (samp_done) begin
          shreg_d[bit_q] = maj;
        end
        if (bit_end) begin
          if (bit_q == bcnt_t'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP1;
          end else begin
            bit_d = bit_q + bcnt_t'(1);
          end
        end
      end
      ST_PARITY: begin
        if (samp_done) begin
          par_bit_d = maj;
          par_bad_d = ((^shreg_q) ^ maj) != par_typ_q;
        end
        if (bit_end) begin
          state_d = ST_STOP1;
        end
      end
      ST_STOP1: begin
        if (samp_done) begin
          if (!maj) begin
            if (shreg_q == '0 && (!par_en_q || !par_bit_q)) begin
              brk_d = 1'b1;
            end else begin
              stp_bad_d = 1'b1;
            end
            state_d = ST_DONE;
          end else if (!stp2_q) begin
            state_d = ST_DONE;
          end
        end else if (bit_end) begin
          state_d = ST_STOP2;
        end
      end
      ST_STOP2: begin
        if (samp_done) begin
          if (!maj) begin
            stp_bad_d = 1'b1;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = brk_q ? ST_BRK_WAIT : ST_IDLE;
      end
      ST_BRK_WAIT: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pulses are registered so they line up with the DONE cycle.
    if (state_d == ST_DONE) begin
      dv_d = ~par_bad_d & ~stp_bad_d & ~brk_d;
      pe_d = par_bad_d;
      se_d = stp_bad_d & ~brk_d;
      bd_d = brk_d;
      if (dv_d) begin
        pdata_d = shreg_d;
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q    <= '1;
      state_q   <= ST_IDLE;
      bit_q     <= '0;
      shreg_q   <= '0;
      pdata_q   <= '0;
      presc_q   <= psc_t'(MIN_PRESCALE);
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stp2_q    <= 1'b0;
      par_bad_q <= 1'b0;
      stp_bad_q <= 1'b0;
      brk_q     <= 1'b0;
      par_bit_q <= 1'b0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
      bd_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      pdata_q   <= pdata_d;
      presc_q   <= presc_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      stp2_q    <= stp2_d;
      par_bad_q <= par_bad_d;
      stp_bad_q <= stp_bad_d;
      brk_q     <= brk_d;
      par_bit_q <= par_bit_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
      bd_q      <= bd_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.P_DATA     = pdata_q;
  assign bus.Data_Valid = dv_q;
  assign bus.Par_Err    = pe_q;
  assign bus.Stp_Err    = se_q;
  assign bus.Brk_Det    = bd_q;
  assign bus.Busy       = busy_q;

endmodule
